// File: rtl/aqua_pkg.sv
// aqua_pkg -- shared issue-path types for the ALU front end.
//   operator_e  : ALU operation code carried with each issued op
//   alu_issue_s : one issue package (valid flag, operation, two operands)
//   arb_src_e   : which requester an op held at the ALU came from
package aqua_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_LW  = 4'd7,
        OP_SW  = 4'd8,
        OP_BEQ = 4'd9,
        OP_BNE = 4'd10,
        OP_JAL = 4'd11
    } operator_e;

    typedef struct packed {
        logic        valid;
        operator_e   instr;
        logic [31:0] a;
        logic [31:0] b;
    } alu_issue_s;

    typedef enum logic {
        SRC_BR = 1'b0,
        SRC_EX = 1'b1
    } arb_src_e;

endpackage

// File: rtl/alu_issue_slot.sv
// alu_issue_slot -- single-entry output register in front of the ALU.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : capture in_pkg/in_src this edge (valid forced to 1)
//   drain      : slot may be emptied this edge (consumed, idle or flushed)
//   in_pkg     : package to capture
//   in_src     : source tag to capture
//   out_pkg    : registered package presented to the ALU
//   out_src    : source tag of out_pkg
// With neither load nor drain the slot holds every bit unchanged.
module alu_issue_slot
    import aqua_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       drain,
    input  alu_issue_s in_pkg,
    input  arb_src_e   in_src,
    output alu_issue_s out_pkg,
    output arb_src_e   out_src
);

    alu_issue_s loaded;

    always_comb begin
        loaded       = in_pkg;
        loaded.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_pkg <= '0;
            out_src <= SRC_BR;
        end else if (load) begin
            out_pkg <= loaded;
            out_src <= in_src;
        end else if (drain) begin
            // Only the valid bit drops; payload bits are left as they were.
            out_pkg.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter -- two-requester issue arbiter feeding one ALU slot.
//   i_clk, i_rst_n : clock and synchronous active-low reset
//   i_br_pkg       : requester 0 (branch/jump), .valid is its request
//   o_br_ready     : requester 0 accepted when i_br_pkg.valid && o_br_ready
//   i_ex_pkg       : requester 1 (arith/load/store), .valid is its request
//   o_ex_ready     : requester 1 accepted when i_ex_pkg.valid && o_ex_ready
//   i_alu_ready    : ALU consumes o_alu_pkg when o_alu_pkg.valid && i_alu_ready
//   i_invalidate   : flush the held op and refuse new ops this cycle
//   o_alu_pkg      : registered op for the ALU
//   o_grant_src    : source of the op held in o_alu_pkg
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; ready is computed combinationally from valid and slot state,
// and a requester that is not accepted may change its package freely.
// BR normally wins a contested cycle; after STARVE_LIMIT consecutive
// contested losses EX is forced to win once.
module alu_issue_arbiter
    import aqua_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
)
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  alu_issue_s i_br_pkg,
    output logic       o_br_ready,
    input  alu_issue_s i_ex_pkg,
    output logic       o_ex_ready,
    input  logic       i_alu_ready,
    input  logic       i_invalidate,
    output alu_issue_s o_alu_pkg,
    output arb_src_e   o_grant_src
);

    localparam int unsigned     CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          can_load;
    logic          contested;
    logic          ex_wins;
    logic          br_wins;
    logic          accept;
    arb_src_e      win_src;
    alu_issue_s    win_pkg;

    always_comb begin
        can_load   = (!o_alu_pkg.valid || i_alu_ready) && !i_invalidate;
        contested  = i_br_pkg.valid && i_ex_pkg.valid;
        ex_wins    = i_ex_pkg.valid && (!i_br_pkg.valid || starve_cnt == LIMIT_C);
        br_wins    = i_br_pkg.valid && !ex_wins;
        o_br_ready = i_rst_n && br_wins && can_load;
        o_ex_ready = i_rst_n && ex_wins && can_load;
        // Each ready already implies its requester is valid.
        accept     = o_br_ready || o_ex_ready;
        win_src    = ex_wins ? SRC_EX : SRC_BR;
        win_pkg    = ex_wins ? i_ex_pkg : i_br_pkg;
    end

    // Counts contested cycles that BR won while EX waited.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_invalidate || o_ex_ready) begin
            starve_cnt <= '0;
        end else if (contested && can_load && br_wins && starve_cnt != LIMIT_C) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    alu_issue_slot u_slot (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (accept),
        .drain   (can_load || i_invalidate),
        .in_pkg  (win_pkg),
        .in_src  (win_src),
        .out_pkg (o_alu_pkg),
        .out_src (o_grant_src)
    );

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
    import aqua_pkg::*;

    localparam int LIMIT = 3;
    localparam int W     = $bits(alu_issue_s) + 1;

    logic       clk;
    logic       rst_n;
    alu_issue_s br_pkg;
    alu_issue_s ex_pkg;
    logic       br_rdy;
    logic       ex_rdy;
    logic       alu_rdy;
    logic       inv;
    alu_issue_s alu_pkg;
    arb_src_e   grant_src;

    alu_issue_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_br_pkg     (br_pkg),
        .o_br_ready   (br_rdy),
        .i_ex_pkg     (ex_pkg),
        .o_ex_ready   (ex_rdy),
        .i_alu_ready  (alu_rdy),
        .i_invalidate (inv),
        .o_alu_pkg    (alu_pkg),
        .o_grant_src  (grant_src)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic alu_issue_s mk(bit v, operator_e op, logic [31:0] a, logic [31:0] b);
        alu_issue_s p;
        p.valid = v;
        p.instr = op;
        p.a     = a;
        p.b     = b;
        return p;
    endfunction

    // ---------------- reference model ----------------
    // What the ALU should see next, plus how many contested cycles EX has
    // lost since it was last served.
    alu_issue_s m_pkg;
    arb_src_e   m_src;
    int         m_losses;
    logic [W-1:0] exp_q[$];
    int         ex_wait;
    bit         seen_br, seen_ex;

    // One clock: inputs must already be driven; called at posedge+1.
    task automatic cycle();
        bit can, both, ex_turn, e_br, e_ex;
        alu_issue_s nxt;
        #3;
        seen_br = br_rdy;
        seen_ex = ex_rdy;

        can     = rst_n && !inv && (!m_pkg.valid || alu_rdy);
        both    = br_pkg.valid && ex_pkg.valid;
        ex_turn = ex_pkg.valid && (!br_pkg.valid || m_losses >= LIMIT);
        e_ex    = can && ex_turn;
        e_br    = can && br_pkg.valid && !ex_turn;
        chk("br_ready", seen_br, e_br);
        chk("ex_ready", seen_ex, e_ex);

        // EX wait bound, judged from what the DUT actually granted.
        if (!rst_n || inv || (ex_pkg.valid && seen_ex)) ex_wait = 0;
        else if (both && can && seen_br) begin
            ex_wait++;
            chk("ex_wait_bound", ex_wait <= LIMIT, 1);
        end

        // Scoreboard: the held op leaves either killed or consumed once.
        if (m_pkg.valid && (!rst_n || inv)) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (m_pkg.valid && alu_rdy) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_consume", {grant_src, alu_pkg}, exp_q.pop_front());
        end

        if (!rst_n) begin
            m_pkg = '0; m_src = SRC_BR; m_losses = 0;
        end else if (inv) begin
            m_pkg.valid = 1'b0; m_losses = 0;
        end else if (e_br || e_ex) begin
            nxt = e_ex ? ex_pkg : br_pkg;
            nxt.valid = 1'b1;
            m_pkg = nxt;
            m_src = e_ex ? SRC_EX : SRC_BR;
            if (e_ex) m_losses = 0;
            else if (both && m_losses < LIMIT) m_losses++;
            exp_q.push_back({m_src, m_pkg});
        end else if (can) begin
            m_pkg.valid = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("alu_pkg", alu_pkg, m_pkg);
        chk("grant_src", grant_src, m_src);
        chk("starve_cnt", dut.starve_cnt, m_losses);
    endtask

    task automatic idle_inputs();
        br_pkg  = '0;
        ex_pkg  = '0;
        alu_rdy = 1'b1;
        inv     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit       br_v, ex_v, rdy, inv;
        bit       e_br, e_ex, e_valid;
        arb_src_e e_src;
    } vec_t;

    vec_t vecs[8];
    arb_src_e exp_seq[8];

    initial begin
        int peak;
        alu_issue_s held;

        rst_n = 1'b0;
        idle_inputs();
        m_pkg = '0; m_src = SRC_BR; m_losses = 0; ex_wait = 0;

        vecs[0] = '{0, 0, 1, 0, 0, 0, 0, SRC_BR};
        vecs[1] = '{1, 0, 1, 0, 1, 0, 1, SRC_BR};
        vecs[2] = '{0, 1, 1, 0, 0, 1, 1, SRC_EX};
        vecs[3] = '{1, 1, 1, 0, 1, 0, 1, SRC_BR};
        vecs[4] = '{1, 1, 0, 0, 1, 0, 1, SRC_BR};
        vecs[5] = '{1, 1, 1, 1, 0, 0, 0, SRC_BR};
        vecs[6] = '{0, 1, 0, 1, 0, 0, 0, SRC_BR};
        vecs[7] = '{1, 0, 1, 1, 0, 0, 0, SRC_BR};

        exp_seq = '{SRC_BR, SRC_BR, SRC_BR, SRC_EX, SRC_BR, SRC_BR, SRC_BR, SRC_EX};

        @(posedge clk);
        #1;
        do_reset();
        chk("reset_valid", alu_pkg, '0);
        chk("reset_src", grant_src, SRC_BR);

        // Table: each vector applied to an empty slot right after reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            br_pkg  = mk(vecs[i].br_v, OP_BEQ, 32'(i), 32'h5);
            ex_pkg  = mk(vecs[i].ex_v, OP_ADD, 32'h7, 32'(i));
            alu_rdy = vecs[i].rdy;
            inv     = vecs[i].inv;
            cycle();
            chk($sformatf("vec%0d_br_ready", i), seen_br, vecs[i].e_br);
            chk($sformatf("vec%0d_ex_ready", i), seen_ex, vecs[i].e_ex);
            chk($sformatf("vec%0d_valid", i), alu_pkg.valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_src", i), grant_src, vecs[i].e_src);
        end

        // BR alone after idle: accepted same cycle, presented next cycle.
        do_reset();
        cycle();
        br_pkg = mk(1, OP_BEQ, 32'd5, 32'd5);
        cycle();
        chk("br_only_ready", seen_br, 1);
        chk("br_only_valid", alu_pkg.valid, 1);
        chk("br_only_instr", alu_pkg.instr, OP_BEQ);
        chk("br_only_src", grant_src, SRC_BR);

        // Starvation rotation with both requesters always valid.
        do_reset();
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            br_pkg = mk(1, OP_BNE, 32'(i), 32'h0);
            ex_pkg = mk(1, OP_ADD, 32'(i), 32'h1);
            cycle();
            chk($sformatf("starve_seq%0d", i), grant_src, exp_seq[i]);
            if (int'(dut.starve_cnt) > peak) peak = int'(dut.starve_cnt);
        end
        chk("starve_peak", peak, 3);

        // Backpressure: held ADD stays put while ALU stalls.
        do_reset();
        br_pkg = mk(1, OP_ADD, 32'h10, 32'h20);
        cycle();
        held = alu_pkg;
        chk("bp_loaded", held, mk(1, OP_ADD, 32'h10, 32'h20));
        br_pkg  = mk(1, OP_BNE, 32'h1, 32'h2);
        ex_pkg  = mk(1, OP_SUB, 32'h3, 32'h4);
        alu_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold", alu_pkg, held);
            chk("bp_readies", {seen_br, seen_ex}, 2'b00);
        end
        alu_rdy = 1'b1;
        cycle();
        chk("bp_release_ready", seen_br, 1);
        chk("bp_no_bubble", alu_pkg, mk(1, OP_BNE, 32'h1, 32'h2));

        // Invalidate while a SUB is held and stalled.
        do_reset();
        ex_pkg = mk(1, OP_SUB, 32'h9, 32'h3);
        cycle();
        chk("inv_loaded_src", grant_src, SRC_EX);
        ex_pkg  = mk(1, OP_XOR, 32'hA, 32'hB);
        alu_rdy = 1'b0;
        inv     = 1'b1;
        cycle();
        chk("inv_ex_ready", seen_ex, 0);
        chk("inv_valid", alu_pkg.valid, 0);
        chk("inv_starve", dut.starve_cnt, 0);
        inv = 1'b0;
        cycle();
        chk("inv_after_ready", seen_ex, 1);
        chk("inv_after_pkg", alu_pkg, mk(1, OP_XOR, 32'hA, 32'hB));

        // Reset while an op is held.
        do_reset();
        br_pkg = mk(1, OP_JAL, 32'h44, 32'h55);
        cycle();
        alu_rdy = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("rst_readies", {seen_br, seen_ex}, 2'b00);
        chk("rst_pkg", alu_pkg, '0);
        chk("rst_src", grant_src, SRC_BR);
        rst_n   = 1'b1;
        alu_rdy = 1'b1;
        cycle();
        chk("rst_reload", alu_pkg, mk(1, OP_JAL, 32'h44, 32'h55));

        // Random soak against the model and scoreboard.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            br_pkg  = mk($urandom_range(0, 99) < 60, operator_e'($urandom_range(0, 11)),
                         $urandom, $urandom);
            ex_pkg  = mk($urandom_range(0, 99) < 60, operator_e'($urandom_range(0, 11)),
                         $urandom, $urandom);
            alu_rdy = $urandom_range(0, 99) < 70;
            inv     = $urandom_range(0, 99) < 5;
            cycle();
        end
        chk("sb_final_depth", exp_q.size(), m_pkg.valid ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
